control_pipeline: RTL and testbench
===================================

# control_pipeline

Carries the decoded control word from the control unit through the EX, MEM and WB pipeline stages of the LAPI DOpaCA LAMBA core. It registers and propagates the control word stage by stage and resolves the write-back destination register. It also detects load-use hazards (stall plus bubble) and squashes the wrong-path instruction when a jump or taken branch is resolved in EX. It sits between the control unit / ID stage and the datapath pipeline registers.

## Interface
- REG_ADDR_W, 5, register address width
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_reg_dst_mux, id_reg_write_enable, id_alu_src_mux, id_mem_write_enable, id_fl_write_enable, id_sel_jt_jf, id_sel_beq_bne, id_sel_branch_jflag, id_is_branch, id_is_jump  in  1 each  control unit outputs
- id_wb_res_mux  in  2  write-back source select (0 ALU, 1 memory)
- id_rs, id_rt, id_rd  in  REG_ADDR_W  instruction register fields
- id_uses_rt  in  1  rt is a source operand
- ex_branch_taken  in  1  branch condition true, from EX datapath
- ex_alu_src_mux, ex_sel_jt_jf, ex_sel_beq_bne, ex_sel_branch_jflag, ex_fl_write_enable  out  1 each  EX controls
- mem_mem_write_enable  out  1  data memory write strobe
- wb_reg_write_enable, wb_fl_write_enable  out  1  write-back enables
- wb_wb_res_mux  out  2  write-back mux select
- wb_dst  out  REG_ADDR_W  write-back register address
- stall  out  1  hold PC and IF/ID
- flush  out  1  squash IF/ID

## Operation
- There are three stage registers: EX, MEM, WB. Each holds a valid bit, the control fields the stage still needs, and dst.
- dst is resolved on ID→EX: rd if id_reg_dst_mux=1, else rt.
- Every side-effect output is the stage register ANDed with valid: fl/mem/reg write enables, and flush.
- wb_reg_write_enable is additionally forced to 0 when wb_dst=0.
- Load-use hazard. All of the following must hold:
  - ex_valid, ex_reg_write_enable, and ex_wb_res_mux=1;
  - ex_dst≠0 and id_valid;
  - ex_dst==id_rs, or (id_uses_rt and ex_dst==id_rt).
- When a load-use hazard is detected: stall=1, and EX loads a bubble (valid=0, all fields 0) next cycle.
- EX→MEM and MEM→WB always advance; there is no downstream stall.
- Flush condition: ex_valid and (ex_is_jump or (ex_is_branch and ex_branch_taken)).
- When flush is active:
  - flush=1;
  - EX loads a bubble next cycle;
  - stall is forced 0, because the flush has priority and the hazarding ID instruction is itself squashed.
- The instruction in EX at flush time completes normally.
- ID→EX takes id_* when there is no stall and no flush, or a bubble when id_valid=0.

## Timing
- Reset: all valid bits 0, all fields 0, all outputs 0, including stall and flush. Asserting rst mid-operation clears everything asynchronously. Nothing is committed from in-flight instructions.
- Latency: ID→EX, EX→MEM and MEM→WB are 1 cycle each. An instruction accepted at edge N shows wb_* after edge N+2.
- stall and flush are combinational, settled in the same cycle as their causes.
- A stall lasts exactly 1 cycle per load-use pair. On the next cycle the load is in MEM and no longer matches.
- Back-to-back flushes are impossible, because a bubble follows every flush.

## Configuration
- CTRL_PIPE_HAZARD_EN
  - Defined: load-use detection and stall behave as above.
  - Undefined: stall is tied 0, no bubble is inserted for hazards, and software must schedule a nop after loads. Flush logic is unaffected.

## Structure
- Shared package/defines:
  - WB_SRC_ALU=2'd0 and WB_SRC_MEM=2'd1;
  - REG_ZERO=0;
  - existing OP_* opcode defines;
  - a typedef/struct for the stage control word.
- Sub-module: hazard_detect, the combinational load-use comparator. It is instantiated only under CTRL_PIPE_HAZARD_EN.

## Test plan
- Reset: hold rst with random inputs → every output 0. Release rst → stays 0 until id_valid.
- Pass-through: R-type (reg_dst_mux=1, rd=7, wb_res_mux=0, fl_we=1) issued at cycle 0 → ex_fl_write_enable=1 at 1; wb_dst=7, wb_reg_write_enable=1, wb_wb_res_mux=0 at 3.
- Load-use: load rt=5 followed by R-type rs=5 → stall=1 for exactly one cycle. A bubble follows the load. wb_reg_write_enable is high for the load, then 0 for the bubble, then 1 for the R-type.
- Zero register: load to rt=0 followed by consumer rs=0 → no stall. wb_reg_write_enable=0 for that load.
- Flush priority: EX holds a taken branch with ex_branch_taken=1 while ID matches an EX load condition → flush=1, stall=0, and the next EX is a bubble.
- Store: id_mem_write_enable=1 issued at cycle 0 → mem_mem_write_enable=1 only in cycle 2. When squashed by a jump in EX, the store never raises mem_mem_write_enable.

Source files
------------

// File: rtl/control_pipeline_pkg.sv
// Shared constants and stage control-word types for control_pipeline.
package control_pipeline_pkg;

    localparam logic [1:0] WB_SRC_ALU = 2'd0;
    localparam logic [1:0] WB_SRC_MEM = 2'd1;
    localparam int         REG_ZERO   = 0;

    typedef struct packed {
        logic       valid;
        logic       alu_src;
        logic       sel_jt_jf;
        logic       sel_beq_bne;
        logic       sel_branch_jflag;
        logic       is_branch;
        logic       is_jump;
        logic       fl_we;
        logic       mem_we;
        logic       reg_we;
        logic [1:0] wb_res_mux;
    } ex_ctrl_t;

    typedef struct packed {
        logic       valid;
        logic       fl_we;
        logic       mem_we;
        logic       reg_we;
        logic [1:0] wb_res_mux;
    } mem_ctrl_t;

    typedef struct packed {
        logic       valid;
        logic       fl_we;
        logic       reg_we;
        logic [1:0] wb_res_mux;
    } wb_ctrl_t;

endpackage

// File: rtl/control_pipeline_hazard_detect.sv
// Combinational load-use comparator between the EX load and the ID consumer.
module hazard_detect
    import control_pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  ex_valid,
    input  logic                  ex_reg_we,
    input  logic [1:0]            ex_wb_res_mux,
    input  logic [REG_ADDR_W-1:0] ex_dst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    output logic                  hazard
);

    logic ex_is_load;
    logic src_match;

    always_comb begin
        ex_is_load = ex_valid && ex_reg_we && (ex_wb_res_mux == WB_SRC_MEM);
        src_match  = (ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt));
        hazard     = ex_is_load && id_valid && src_match
                  && (ex_dst != REG_ADDR_W'(REG_ZERO));
    end

endmodule

// File: rtl/control_pipeline.sv
// EX/MEM/WB control-word pipeline with load-use stall and jump/branch flush.
// Load-use detection is built only when CTRL_PIPE_HAZARD_EN is defined.
module control_pipeline
    import control_pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic                  id_reg_dst_mux,
    input  logic                  id_reg_write_enable,
    input  logic                  id_alu_src_mux,
    input  logic                  id_mem_write_enable,
    input  logic                  id_fl_write_enable,
    input  logic                  id_sel_jt_jf,
    input  logic                  id_sel_beq_bne,
    input  logic                  id_sel_branch_jflag,
    input  logic                  id_is_branch,
    input  logic                  id_is_jump,
    input  logic [1:0]            id_wb_res_mux,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_uses_rt,
    input  logic                  ex_branch_taken,
    output logic                  ex_alu_src_mux,
    output logic                  ex_sel_jt_jf,
    output logic                  ex_sel_beq_bne,
    output logic                  ex_sel_branch_jflag,
    output logic                  ex_fl_write_enable,
    output logic                  mem_mem_write_enable,
    output logic                  wb_reg_write_enable,
    output logic                  wb_fl_write_enable,
    output logic [1:0]            wb_wb_res_mux,
    output logic [REG_ADDR_W-1:0] wb_dst,
    output logic                  stall,
    output logic                  flush
);

    ex_ctrl_t              ex_q, ex_d;
    mem_ctrl_t             mem_q, mem_d;
    wb_ctrl_t              wb_q, wb_d;
    logic [REG_ADDR_W-1:0] ex_dst_q, ex_dst_d;
    logic [REG_ADDR_W-1:0] mem_dst_q, mem_dst_d;
    logic [REG_ADDR_W-1:0] wb_dst_q, wb_dst_d;
    logic                  hazard;
    logic                  flush_c;
    logic                  stall_c;

`ifdef CTRL_PIPE_HAZARD_EN
    hazard_detect #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_hazard (
        .ex_valid     (ex_q.valid),
        .ex_reg_we    (ex_q.reg_we),
        .ex_wb_res_mux(ex_q.wb_res_mux),
        .ex_dst       (ex_dst_q),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .hazard       (hazard)
    );
`else
    // Without detection, software schedules a nop after every load.
    logic unused_hazard_inputs;
    assign unused_hazard_inputs = ^{id_rs, id_uses_rt};
    assign hazard = 1'b0;
`endif

    always_comb begin
        flush_c = ex_q.valid
               && (ex_q.is_jump || (ex_q.is_branch && ex_branch_taken));
        // A flush squashes the ID instruction, so its hazard is moot.
        stall_c = hazard && !flush_c;

        ex_d     = '0;
        ex_dst_d = '0;
        if (id_valid && !stall_c && !flush_c) begin
            ex_d.valid            = 1'b1;
            ex_d.alu_src          = id_alu_src_mux;
            ex_d.sel_jt_jf        = id_sel_jt_jf;
            ex_d.sel_beq_bne      = id_sel_beq_bne;
            ex_d.sel_branch_jflag = id_sel_branch_jflag;
            ex_d.is_branch        = id_is_branch;
            ex_d.is_jump          = id_is_jump;
            ex_d.fl_we            = id_fl_write_enable;
            ex_d.mem_we           = id_mem_write_enable;
            ex_d.reg_we           = id_reg_write_enable;
            ex_d.wb_res_mux       = id_wb_res_mux;
            ex_dst_d              = id_reg_dst_mux ? id_rd : id_rt;
        end

        mem_d.valid      = ex_q.valid;
        mem_d.fl_we      = ex_q.fl_we;
        mem_d.mem_we     = ex_q.mem_we;
        mem_d.reg_we     = ex_q.reg_we;
        mem_d.wb_res_mux = ex_q.wb_res_mux;
        mem_dst_d        = ex_dst_q;

        wb_d.valid      = mem_q.valid;
        wb_d.fl_we      = mem_q.fl_we;
        wb_d.reg_we     = mem_q.reg_we;
        wb_d.wb_res_mux = mem_q.wb_res_mux;
        wb_dst_d        = mem_dst_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            ex_dst_q  <= '0;
            mem_dst_q <= '0;
            wb_dst_q  <= '0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            ex_dst_q  <= ex_dst_d;
            mem_dst_q <= mem_dst_d;
            wb_dst_q  <= wb_dst_d;
        end
    end

    assign ex_alu_src_mux       = ex_q.alu_src;
    assign ex_sel_jt_jf         = ex_q.sel_jt_jf;
    assign ex_sel_beq_bne       = ex_q.sel_beq_bne;
    assign ex_sel_branch_jflag  = ex_q.sel_branch_jflag;
    assign ex_fl_write_enable   = ex_q.valid & ex_q.fl_we;
    assign mem_mem_write_enable = mem_q.valid & mem_q.mem_we;
    assign wb_reg_write_enable  = wb_q.valid & wb_q.reg_we
                               & (wb_dst_q != REG_ADDR_W'(REG_ZERO));
    assign wb_fl_write_enable   = wb_q.valid & wb_q.fl_we;
    assign wb_wb_res_mux        = wb_q.wb_res_mux;
    assign wb_dst               = wb_dst_q;
    assign stall                = stall_c;
    assign flush                = flush_c;

endmodule

// File: tb/tb_control_pipeline.sv
// Randomized scoreboard bench for control_pipeline.
// Checks against an instruction-level model.
module tb_control_pipeline;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_reg_dst_mux;
  logic       id_reg_write_enable, id_alu_src_mux;
  logic       id_mem_write_enable, id_fl_write_enable;
  logic       id_sel_jt_jf, id_sel_beq_bne;
  logic       id_sel_branch_jflag, id_is_branch;
  logic       id_is_jump;
  logic [1:0] id_wb_res_mux;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_uses_rt, ex_branch_taken;
  logic       ex_alu_src_mux, ex_sel_jt_jf;
  logic       ex_sel_beq_bne, ex_sel_branch_jflag;
  logic       ex_fl_write_enable, mem_mem_write_enable;
  logic       wb_reg_write_enable, wb_fl_write_enable;
  logic [1:0] wb_wb_res_mux;
  logic [4:0] wb_dst;
  logic       stall, flush;

  control_pipeline #(.REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid),
    .id_reg_dst_mux(id_reg_dst_mux),
    .id_reg_write_enable(id_reg_write_enable),
    .id_alu_src_mux(id_alu_src_mux),
    .id_mem_write_enable(id_mem_write_enable),
    .id_fl_write_enable(id_fl_write_enable),
    .id_sel_jt_jf(id_sel_jt_jf),
    .id_sel_beq_bne(id_sel_beq_bne),
    .id_sel_branch_jflag(id_sel_branch_jflag),
    .id_is_branch(id_is_branch),
    .id_is_jump(id_is_jump),
    .id_wb_res_mux(id_wb_res_mux),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt),
    .ex_branch_taken(ex_branch_taken),
    .ex_alu_src_mux(ex_alu_src_mux),
    .ex_sel_jt_jf(ex_sel_jt_jf),
    .ex_sel_beq_bne(ex_sel_beq_bne),
    .ex_sel_branch_jflag(ex_sel_branch_jflag),
    .ex_fl_write_enable(ex_fl_write_enable),
    .mem_mem_write_enable(mem_mem_write_enable),
    .wb_reg_write_enable(wb_reg_write_enable),
    .wb_fl_write_enable(wb_fl_write_enable),
    .wb_wb_res_mux(wb_wb_res_mux),
    .wb_dst(wb_dst),
    .stall(stall), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit       v, reg_dst, reg_we, alu_src, mem_we, fl_we;
    bit       jt, beq, bj, is_br, is_j, uses_rt;
    bit [1:0] res;
    bit [4:0] rs, rt, rd;
  } ins_t;

  typedef struct packed {
    logic       stall, flush, alu, jt, beq, bj;
    logic       ex_fl, mem_we, wb_re, wb_fl;
    logic [1:0] wb_res;
    logic [4:0] wb_dst;
  } obs_t;

  obs_t exp_q[$];
  ins_t prog[$];
  int   n_pass = 0;
  int   n_chk  = 0;
  int   cyc    = 0;

  ins_t ex_m, mem_m, wb_m, hold_i;
  bit   holding;

  function automatic bit [4:0] dst_of(ins_t i);
    return i.reg_dst ? i.rd : i.rt;
  endfunction

  function automatic ins_t mk_alu(
    bit [4:0] rs, bit [4:0] rt, bit [4:0] rd, bit fl);
    ins_t i = '0;
    i.v = 1; i.reg_dst = 1; i.reg_we = 1;
    i.uses_rt = 1; i.fl_we = fl;
    i.rs = rs; i.rt = rt; i.rd = rd;
    return i;
  endfunction

  function automatic ins_t mk_load(bit [4:0] rs, bit [4:0] rt);
    ins_t i = '0;
    i.v = 1; i.reg_we = 1; i.alu_src = 1; i.res = 2'd1;
    i.rs = rs; i.rt = rt; i.rd = 5'(rt + 3);
    return i;
  endfunction

  function automatic ins_t mk_store(bit [4:0] rs, bit [4:0] rt);
    ins_t i = '0;
    i.v = 1; i.mem_we = 1; i.alu_src = 1; i.uses_rt = 1;
    i.rs = rs; i.rt = rt;
    return i;
  endfunction

  function automatic ins_t mk_jump();
    ins_t i = '0;
    i.v = 1; i.is_j = 1; i.jt = 1; i.bj = 1;
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    i = ins_t'({$urandom, $urandom});
    i.rs = 5'($urandom_range(0, 7));
    i.rt = 5'($urandom_range(0, 7));
    i.rd = 5'($urandom_range(0, 7));
    i.v  = ($urandom_range(0, 9) < 7);
    case ($urandom_range(0, 5))
      0: i = mk_alu(i.rs, i.rt, i.rd, i.fl_we);
      1: i = mk_load(i.rs, i.rt);
      2: i = mk_store(i.rs, i.rt);
      3: begin
        i = mk_store(i.rs, i.rt);
        i.mem_we = 0; i.alu_src = 0;
        i.is_br = 1; i.beq = i.rs[0];
      end
      4: i = mk_jump();
      default: ;
    endcase
    return i;
  endfunction

  task automatic drive(ins_t i);
    id_valid = i.v; id_reg_dst_mux = i.reg_dst;
    id_reg_write_enable = i.reg_we;
    id_alu_src_mux = i.alu_src;
    id_mem_write_enable = i.mem_we;
    id_fl_write_enable = i.fl_we;
    id_sel_jt_jf = i.jt; id_sel_beq_bne = i.beq;
    id_sel_branch_jflag = i.bj; id_is_branch = i.is_br;
    id_is_jump = i.is_j; id_wb_res_mux = i.res;
    id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
    id_uses_rt = i.uses_rt;
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    rst = 1;
    drive(rnd_ins());
    ex_branch_taken = 1'($urandom);
    ex_m = '0; mem_m = '0; wb_m = '0; holding = 0;
    exp_q.push_back('0);
  endtask

  task automatic step(bit taken);
    ins_t cur;
    obs_t e;
    bit   fl, st, hz;
    bit [4:0] ed;
    @(negedge clk);
    rst = 0;
    if (holding) cur = hold_i;
    else if (prog.size() > 0) cur = prog.pop_front();
    else begin cur = rnd_ins(); cur.v = 0; end
    drive(cur);
    ex_branch_taken = taken;
    ed = dst_of(ex_m);
    fl = ex_m.v && (ex_m.is_j || (ex_m.is_br && taken));
    hz = ex_m.v && ex_m.reg_we && ex_m.res == 2'd1
      && ed != 0 && cur.v
      && (ed == cur.rs || (cur.uses_rt && ed == cur.rt));
    st = 0;
`ifdef CTRL_PIPE_HAZARD_EN
    st = hz && !fl;
`endif
    e = '0;
    e.stall  = st;
    e.flush  = fl;
    e.alu    = ex_m.alu_src;
    e.jt     = ex_m.jt;
    e.beq    = ex_m.beq;
    e.bj     = ex_m.bj;
    e.ex_fl  = ex_m.v && ex_m.fl_we;
    e.mem_we = mem_m.v && mem_m.mem_we;
    e.wb_re  = wb_m.v && wb_m.reg_we && dst_of(wb_m) != 0;
    e.wb_fl  = wb_m.v && wb_m.fl_we;
    e.wb_res = wb_m.res;
    e.wb_dst = dst_of(wb_m);
    exp_q.push_back(e);
    wb_m  = mem_m;
    mem_m = ex_m;
    ex_m  = (cur.v && !fl && !st) ? cur : '0;
    hold_i  = cur;
    holding = st;
  endtask

  task automatic run_prog(int extra, bit taken);
    while (prog.size() > 0 || holding) step(taken);
    repeat (extra) step(taken);
  endtask

  initial begin : monitor
    obs_t a, e;
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      a = {stall, flush, ex_alu_src_mux, ex_sel_jt_jf,
           ex_sel_beq_bne, ex_sel_branch_jflag,
           ex_fl_write_enable, mem_mem_write_enable,
           wb_reg_write_enable, wb_fl_write_enable,
           wb_wb_res_mux, wb_dst};
      if (rst === 1'b1) begin
        n_chk++;
        if (a === '0) n_pass++;
        else $display("FAIL reset cycle %0d: outputs %h not 0",
          cyc, a);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL outputs cycle %0d: got st=%b fl=%b ex=%b%b%b%b%b mwe=%b wre=%b wfl=%b res=%0d dst=%0d, want st=%b fl=%b ex=%b%b%b%b%b mwe=%b wre=%b wfl=%b res=%0d dst=%0d",
          cyc, a.stall, a.flush, a.alu, a.jt, a.beq, a.bj,
          a.ex_fl, a.mem_we, a.wb_re, a.wb_fl, a.wb_res,
          a.wb_dst, e.stall, e.flush, e.alu, e.jt, e.beq,
          e.bj, e.ex_fl, e.mem_we, e.wb_re, e.wb_fl,
          e.wb_res, e.wb_dst);
      end
    end
  end

  initial begin : driver
    ins_t b;
    rst = 1;
    drive('0);
    ex_branch_taken = 0;
    ex_m = '0; mem_m = '0; wb_m = '0;
    hold_i = '0; holding = 0;
    repeat (3) reset_cycle();
    repeat (3) step(1'($urandom));

    prog.push_back(mk_alu(5'd1, 5'd2, 5'd7, 1'b1));
    run_prog(4, 1'b0);

    prog.push_back(mk_load(5'd1, 5'd5));
    prog.push_back(mk_alu(5'd5, 5'd3, 5'd9, 1'b0));
    prog.push_back(mk_alu(5'd2, 5'd5, 5'd10, 1'b0));
    run_prog(4, 1'b0);

    prog.push_back(mk_load(5'd1, 5'd0));
    prog.push_back(mk_alu(5'd0, 5'd0, 5'd4, 1'b0));
    run_prog(4, 1'b0);

    b = mk_load(5'd2, 5'd6);
    b.is_br = 1;
    prog.push_back(b);
    prog.push_back(mk_alu(5'd6, 5'd1, 5'd3, 1'b1));
    prog.push_back(mk_alu(5'd1, 5'd2, 5'd11, 1'b1));
    run_prog(4, 1'b1);

    prog.push_back(mk_store(5'd3, 5'd4));
    run_prog(4, 1'b0);
    prog.push_back(mk_jump());
    prog.push_back(mk_store(5'd3, 5'd4));
    prog.push_back(mk_alu(5'd1, 5'd1, 5'd12, 1'b0));
    run_prog(4, 1'b0);

    prog.push_back(mk_alu(5'd1, 5'd2, 5'd13, 1'b1));
    prog.push_back(mk_store(5'd1, 5'd2));
    prog.push_back(mk_load(5'd1, 5'd14));
    step(1'b0); step(1'b0); step(1'b0);
    reset_cycle();
    prog.delete();
    repeat (2) step(1'b0);

    for (int n = 0; n < 400; n++) begin
      if (prog.size() == 0) prog.push_back(rnd_ins());
      step(1'($urandom));
      if (n == 200) begin
        reset_cycle();
        reset_cycle();
      end
    end
    prog.delete();
    run_prog(4, 1'b0);

    fork
      wait (exp_q.size() == 0);
      repeat (20) @(negedge clk);
    join_any
    disable fork;
    #5;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL timeout: %0d expectations unchecked",
      exp_q.size());

    @(negedge clk);
    #5;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
